br_predict_unit: RTL
====================

Name: br_predict_unit

Overview:
- Fetch-stage next-PC selector and branch-resolution tracker. It sits downstream of the BTB and consumes btb_hit/branch_address.
- Holds a 2-bit saturating-counter pattern history table (PHT) that gates BTB hits into taken predictions, and drives the IF next PC.
- Each fetched prediction is queued in order. At WB the queued prediction is compared against the resolved outcome. A mispredict produces a registered redirect/flush pulse and trains the PHT.

Parameters:
- PHT_LINES, 32, PHT entries; index = pc[5:1] (log2(PHT_LINES) bits starting at bit 1).
- DEPTH, 8, prediction-queue entries (power of 2, ≥ IF→WB in-flight instructions).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pc_if  in  16  PC of instruction in IF.
- btb_hit  in  1  BTB hit for pc_if.
- branch_address  in  16  BTB target for pc_if.
- fetch_valid  in  1  IF instruction advances to ID this cycle.
- wb_valid  in  1  valid instruction retires in WB this cycle.
- wb_pc  in  16  PC of WB instruction.
- wb_is_branch  in  1  WB instruction is BR/JMP/JSR/TRAP.
- wb_taken  in  1  resolved taken (1 for JMP/JSR/TRAP).
- wb_target  in  16  resolved target (alu_out or trap vector data).
- pc_next  out  16  next PC for IF (combinational).
- pred_taken  out  1  current IF prediction (combinational).
- q_full  out  1  queue full; IF must stall.
- mispredict  out  1  registered one-cycle flush pulse.
- redirect_pc  out  16  correct PC, valid while mispredict=1.

Behaviour:
- Reset (async, reset_n=0): all PHT counters = 2'b01 (weakly not-taken); queue head/tail/count = 0; mispredict=0; redirect_pc=16'h0.
- Prediction (combinational): pred_taken = btb_hit & PHT[pc_if idx][1].
  - pc_next = pred_taken ? branch_address : pc_if+2.
  - Addition is 16-bit and wraps; 16'hFFFE+2 = 16'h0000.
  - When mispredict=1, pc_next = redirect_pc, overriding the prediction.
- Push: on the clock edge with fetch_valid & !q_full & !mispredict_next, write {pc_if, pred_taken, pc_next} at tail.
  - fetch_valid while full: entry dropped; IF is stalled by q_full.
- Pop: on the clock edge with wb_valid & count≠0, pop head and evaluate.
  - actual_next = (wb_is_branch & wb_taken) ? wb_target : wb_pc+2.
  - pred_next = stored predicted next PC.
  - mispredict_next = (actual_next ≠ pred_next) | (stored pc ≠ wb_pc).
  - wb_valid with an empty queue: ignored, no mispredict, no PHT update.
- Flush: if mispredict_next, then at that edge:
  - mispredict←1 and redirect_pc←actual_next.
  - Queue cleared (head=tail, count=0); any simultaneous push is discarded.
  - mispredict returns to 0 the next cycle unless retriggered.
- Simultaneous push and pop without mispredict: count unchanged; pointers wrap modulo DEPTH.
- PHT training: on pop with wb_is_branch, counter at wb_pc index saturates up if wb_taken, down otherwise (11 stays 11, 00 stays 00). Non-branches do not train.
- Read/write same PHT index in one cycle: the read sees the old value.
- Latency: prediction 0 cycles; mispredict/redirect 1 cycle after the WB pop edge.
- q_full = (count == DEPTH), registered-state derived.

Optional Feature:
- Macro BR_PRED_STATS_EN.
- Defined: adds outputs stat_branches[15:0] and stat_mispredicts[15:0].
  - stat_branches counts pops with wb_is_branch; stat_mispredicts counts edges setting mispredict.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- After reset: pc_if=16'h3000, btb_hit=1, branch_address=16'h3040 → pred_taken=0, pc_next=16'h3002 (counter 01).
- Train: retire 1 taken branch at wb_pc=16'h3000 → PHT→10; same IF stimulus → pred_taken=1, pc_next=16'h3040. Two more taken retires → counter stays 11.
- Mispredict: queue entry predicted 16'h3002; WB wb_taken=1, wb_target=16'h3100 → next cycle mispredict=1, redirect_pc=16'h3100, pc_next=16'h3100, q_full=0, count=0. Pulse lasts exactly 1 cycle.
- Non-branch predicted taken (stale BTB): stored pred_next=16'h4000, wb_is_branch=0, wb_pc=16'h3010 → redirect_pc=16'h3012.
- Full/wrap: 8 pushes without pops → q_full=1; 9th fetch_valid not queued; 20 interleaved push+pop cycles → correct FIFO order, no spurious mispredict.
- Async reset mid-flight: assert reset_n=0 between edges while mispredict=1 and count=5 → mispredict=0, q_full=0, PHT back to 01 immediately.

Source files
------------

// File: rtl/br_predict_unit.sv
// Fetch-stage next-PC selector with a 2-bit PHT gating BTB hits, plus an in-order
// prediction queue resolved at WB. Optional counters under `BR_PRED_STATS_EN.
module br_predict_unit #(
  parameter int PHT_LINES = 32,
  parameter int DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc_if,
  input  logic        btb_hit,
  input  logic [15:0] branch_address,
  input  logic        fetch_valid,
  input  logic        wb_valid,
  input  logic [15:0] wb_pc,
  input  logic        wb_is_branch,
  input  logic        wb_taken,
  input  logic [15:0] wb_target,
  output logic [15:0] pc_next,
  output logic        pred_taken,
  output logic        q_full,
  output logic        mispredict,
  output logic [15:0] redirect_pc
`ifdef BR_PRED_STATS_EN
  ,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(PHT_LINES);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Saturating 2-bit counter step toward taken / not-taken.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    case (ctr)
      2'b00:   res = taken ? 2'b01 : 2'b00;
      2'b01:   res = taken ? 2'b10 : 2'b00;
      2'b10:   res = taken ? 2'b11 : 2'b01;
      2'b11:   res = taken ? 2'b11 : 2'b10;
      default: res = 2'b01;
    endcase
    return res;
  endfunction

  logic [1:0]    pht_r [PHT_LINES];
  logic [15:0]   q_pc_r [DEPTH];
  logic [15:0]   q_next_r [DEPTH];
  logic          q_taken_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [AW:0]   count_r;
  logic          mispredict_r;
  logic [15:0]   redirect_pc_r;

  logic [IDX_W-1:0] idx_if_s;
  logic [IDX_W-1:0] idx_wb_s;
  logic             pred_taken_s;
  logic [15:0]      pc_next_s;
  logic             q_full_s;
  logic             pop_s;
  logic             push_s;
  logic [15:0]      actual_next_s;
  logic             mispredict_next_s;
  logic             train_s;
  logic             head_taken_s;
  logic             unused_s;

  // Prediction, queue handshakes and WB resolution.
  always_comb begin
    idx_if_s          = pc_if[IDX_W:1];
    idx_wb_s          = wb_pc[IDX_W:1];
    pred_taken_s      = btb_hit & pht_r[idx_if_s][1];
    pc_next_s         = 16'h0000;
    q_full_s          = (count_r == CNT_FULL);
    pop_s             = wb_valid & (count_r != '0);
    actual_next_s     = wb_pc + 16'd2;
    mispredict_next_s = 1'b0;
    head_taken_s      = q_taken_r[head_r];
    if (mispredict_r) begin
      pc_next_s = redirect_pc_r;
    end else if (pred_taken_s) begin
      pc_next_s = branch_address;
    end else begin
      pc_next_s = pc_if + 16'd2;
    end
    if (wb_is_branch & wb_taken) begin
      actual_next_s = wb_target;
    end else begin
      actual_next_s = wb_pc + 16'd2;
    end
    if (pop_s) begin
      mispredict_next_s = (actual_next_s != q_next_r[head_r]) | (q_pc_r[head_r] != wb_pc);
    end else begin
      mispredict_next_s = 1'b0;
    end
    push_s  = fetch_valid & ~q_full_s & ~mispredict_next_s;
    train_s = pop_s & wb_is_branch;
  end

  assign unused_s = ^{pc_if[15:IDX_W+1], pc_if[0], wb_pc[15:IDX_W+1], wb_pc[0], head_taken_s};

  // Pattern history table: trained by retiring branches only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_LINES; i++) pht_r[i] <= 2'b01;
    end else if (train_s) begin
      pht_r[idx_wb_s] <= sat_update(pht_r[idx_wb_s], wb_taken);
    end
  end

  // Prediction queue storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_r[i]    <= 16'h0000;
        q_next_r[i]  <= 16'h0000;
        q_taken_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      q_pc_r[tail_r]    <= pc_if;
      q_next_r[tail_r]  <= pc_next_s;
      q_taken_r[tail_r] <= pred_taken_s;
    end
  end

  // Queue pointers; a mispredict empties the queue and drops any same-edge push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (mispredict_next_s) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) tail_r <= tail_r + PTR_ONE;
      if (pop_s)  head_r <= head_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered flush pulse and redirect target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mispredict_r  <= 1'b0;
      redirect_pc_r <= 16'h0000;
    end else begin
      mispredict_r <= mispredict_next_s;
      if (mispredict_next_s) redirect_pc_r <= actual_next_s;
    end
  end

  assign pc_next     = pc_next_s;
  assign pred_taken  = pred_taken_s;
  assign q_full      = q_full_s;
  assign mispredict  = mispredict_r;
  assign redirect_pc = redirect_pc_r;

`ifdef BR_PRED_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  logic [15:0] stat_branches_r;
  logic [15:0] stat_mispredicts_r;

  // Saturating branch and mispredict event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches_r    <= 16'h0000;
      stat_mispredicts_r <= 16'h0000;
    end else begin
      if (train_s)           stat_branches_r    <= sat_inc(stat_branches_r);
      if (mispredict_next_s) stat_mispredicts_r <= sat_inc(stat_mispredicts_r);
    end
  end

  assign stat_branches    = stat_branches_r;
  assign stat_mispredicts = stat_mispredicts_r;
`endif

endmodule
